// File: rtl/axi_printf_buffer.sv
// axi_printf_buffer: AXI4 write-only printf sink feeding a byte FIFO.
// Reads answer SLVERR; buffered bytes drain on a valid/ready stream.
package axi_printf_pkg;
  localparam int ID_W   = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic              awvalid;
    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              wvalid;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wlast;
    logic              bready;
    logic              arvalid;
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              rready;
  } s_axi_mosi_t;

  typedef struct packed {
    logic              awready;
    logic              wready;
    logic              bvalid;
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              arready;
    logic              rvalid;
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
  } s_axi_miso_t;
endpackage

module axi_printf_buffer
  import axi_printf_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   arst,
  input  s_axi_mosi_t            axi_mosi,
  output s_axi_miso_t            axi_miso,
  output logic                   char_valid,
  output logic [7:0]             char_data,
  input  logic                   char_ready,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_e;

  w_state_e        r_wstate;
  w_state_e        w_wstate_nxt;
  r_state_e        r_rstate;
  r_state_e        w_rstate_nxt;

  logic [ID_W-1:0] r_awid;
  logic [ID_W-1:0] r_arid;
  logic [7:0]      r_arlen;
  logic [7:0]      r_rcnt;

  logic [7:0]      r_mem [DEPTH];
  logic [AW:0]     r_wptr;
  logic [AW:0]     r_rptr;

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;

  logic            w_aw_hs;
  logic            w_w_hs;
  logic            w_ar_hs;
  logic            w_r_hs;
  logic            w_rlast;

  logic            w_awready;
  logic            w_wready;
  logic            w_bvalid;
  logic            w_arready;
  logic            w_rvalid;

  // Only the low byte lane carries characters; the rest is ignored.
  logic            w_unused;
  assign w_unused = ^{axi_mosi.awaddr, axi_mosi.awlen,
                      axi_mosi.awsize, axi_mosi.awburst,
                      axi_mosi.wdata[DATA_W-1:8],
                      axi_mosi.wstrb[STRB_W-1:1],
                      axi_mosi.araddr, axi_mosi.arsize,
                      axi_mosi.arburst};

  // Extra MSB on the pointers separates full from empty.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

  assign w_push = w_w_hs && axi_mosi.wstrb[0];
  assign w_pop  = !w_empty && char_ready;

  assign char_valid = !w_empty;
  assign char_data  = w_empty ? 8'h00 : r_mem[r_rptr[AW-1:0]];
  assign fifo_level = r_wptr - r_rptr;

  always_ff @(posedge clk) begin
    if (arst) begin
      r_wstate <= W_IDLE;
      r_awid   <= '0;
    end else begin
      r_wstate <= w_wstate_nxt;
      if (w_aw_hs) begin
        r_awid <= axi_mosi.awid;
      end
    end
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    w_aw_hs      = 1'b0;
    w_w_hs       = 1'b0;
    w_awready    = 1'b0;
    w_wready     = 1'b0;
    w_bvalid     = 1'b0;
    unique case (r_wstate)
      W_IDLE: begin
        w_awready = 1'b1;
        if (axi_mosi.awvalid) begin
          w_aw_hs      = 1'b1;
          w_wstate_nxt = W_DATA;
        end
      end
      W_DATA: begin
        w_wready = !w_full;
        if (axi_mosi.wvalid && !w_full) begin
          w_w_hs = 1'b1;
          if (axi_mosi.wlast) begin
            w_wstate_nxt = W_RESP;
          end
        end
      end
      W_RESP: begin
        w_bvalid = 1'b1;
        if (axi_mosi.bready) begin
          w_wstate_nxt = W_IDLE;
        end
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      r_rstate <= R_IDLE;
      r_arid   <= '0;
      r_arlen  <= '0;
      r_rcnt   <= '0;
    end else begin
      r_rstate <= w_rstate_nxt;
      if (w_ar_hs) begin
        r_arid  <= axi_mosi.arid;
        r_arlen <= axi_mosi.arlen;
        r_rcnt  <= '0;
      end else if (w_r_hs) begin
        r_rcnt <= r_rcnt + 8'd1;
      end
    end
  end

  assign w_rlast = (r_rstate == R_DATA) && (r_rcnt == r_arlen);

  always_comb begin
    w_rstate_nxt = r_rstate;
    w_ar_hs      = 1'b0;
    w_r_hs       = 1'b0;
    w_arready    = 1'b0;
    w_rvalid     = 1'b0;
    unique case (r_rstate)
      R_IDLE: begin
        w_arready = 1'b1;
        if (axi_mosi.arvalid) begin
          w_ar_hs      = 1'b1;
          w_rstate_nxt = R_DATA;
        end
      end
      R_DATA: begin
        w_rvalid = 1'b1;
        if (axi_mosi.rready) begin
          w_r_hs = 1'b1;
          if (w_rlast) begin
            w_rstate_nxt = R_IDLE;
          end
        end
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + (AW+1)'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= axi_mosi.wdata[7:0];
    end
  end

  always_comb begin
    axi_miso         = '0;
    axi_miso.awready = w_awready;
    axi_miso.wready  = w_wready;
    axi_miso.bvalid  = w_bvalid;
    axi_miso.bid     = r_awid;
    axi_miso.bresp   = RESP_OKAY;
    axi_miso.arready = w_arready;
    axi_miso.rvalid  = w_rvalid;
    axi_miso.rid     = r_arid;
    axi_miso.rdata   = '0;
    axi_miso.rresp   = w_rvalid ? RESP_SLVERR : RESP_OKAY;
    axi_miso.rlast   = w_rlast;
  end

endmodule

// File: tb/tb_axi_printf_buffer.sv
// tb_axi_printf_buffer: directed stimulus against a queue-based model
// of the printf buffer, checked every cycle plus literal spot checks.
module tb_axi_printf_buffer;
  import axi_printf_pkg::*;

  localparam int DEPTH = 16;
  localparam int BOUND = 400;

  logic        clk = 1'b0;
  logic        arst;
  s_axi_mosi_t mosi;
  s_axi_miso_t miso;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready;
  logic [4:0]  fifo_level;

  logic              t_awvalid, t_wvalid, t_wlast, t_bready;
  logic              t_arvalid, t_rready;
  logic [ID_W-1:0]   t_awid, t_arid;
  logic [7:0]        t_arlen;
  logic [DATA_W-1:0] t_wdata;
  logic [STRB_W-1:0] t_wstrb;

  int n_checks = 0;
  int n_fail = 0;

  // model state
  bit              m_init = 0;
  int              wph, rph, m_rcnt, m_arlen, sz;
  bit              wr_ok;
  logic [ID_W-1:0] m_awid, m_arid;
  logic [7:0]      q[$];
  logic [7:0]      got_q[$];

  logic [7:0] wr_d [32];
  bit         wr_s [32];
  logic [7:0] exp_b [32];

  always #5 clk = ~clk;

  axi_printf_buffer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .arst       (arst),
    .axi_mosi   (mosi),
    .axi_miso   (miso),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready),
    .fifo_level (fifo_level)
  );

  always_comb begin
    mosi         = '0;
    mosi.awvalid = t_awvalid;
    mosi.awid    = t_awid;
    mosi.awaddr  = 32'h1000_0000;
    mosi.wvalid  = t_wvalid;
    mosi.wdata   = t_wdata;
    mosi.wstrb   = t_wstrb;
    mosi.wlast   = t_wlast;
    mosi.bready  = t_bready;
    mosi.arvalid = t_arvalid;
    mosi.arid    = t_arid;
    mosi.arlen   = t_arlen;
    mosi.araddr  = 32'h2000_0000;
    mosi.rready  = t_rready;
  end

  // Model: handshakes are decided from the model's own view of readiness.
  always @(posedge clk) begin
    if (arst) begin
      wph = 0; rph = 0; m_rcnt = 0; m_arlen = 0;
      m_awid = '0; m_arid = '0;
      q.delete();
      m_init = 1;
    end else if (m_init) begin
      sz = q.size();
      wr_ok = (wph == 1) && (sz < DEPTH);
      if (sz != 0 && char_ready) void'(q.pop_front());
      if (wr_ok && t_wvalid && t_wstrb[0]) q.push_back(t_wdata[7:0]);
      case (wph)
        0: if (t_awvalid) begin wph = 1; m_awid = t_awid; end
        1: if (wr_ok && t_wvalid && t_wlast) wph = 2;
        2: if (t_bready) wph = 0;
        default: wph = 0;
      endcase
      if (rph == 0) begin
        if (t_arvalid) begin
          rph = 1; m_arid = t_arid; m_arlen = int'(t_arlen); m_rcnt = 0;
        end
      end else if (t_rready) begin
        if (m_rcnt == m_arlen) rph = 0;
        else m_rcnt++;
      end
    end
  end

  s_axi_miso_t e;
  always @(negedge clk) begin
    if (m_init) begin
      e = '0;
      e.awready = (wph == 0);
      e.wready  = (wph == 1) && (q.size() < DEPTH);
      e.bvalid  = (wph == 2);
      e.bid     = m_awid;
      e.arready = (rph == 0);
      e.rvalid  = (rph == 1);
      e.rid     = m_arid;
      e.rresp   = (rph == 1) ? RESP_SLVERR : RESP_OKAY;
      e.rlast   = (rph == 1) && (m_rcnt == m_arlen);
      n_checks++;
      if (miso !== e) begin
        n_fail++;
        $display("FAIL miso t=%0t act=%h exp=%h", $time, miso, e);
      end
      n_checks++;
      if (char_valid !== (q.size() != 0) ||
          (q.size() != 0 && char_data !== q[0])) begin
        n_fail++;
        $display("FAIL char t=%0t act=%b/%h exp_n=%0d exp=%h",
                 $time, char_valid, char_data, q.size(),
                 (q.size() != 0) ? q[0] : 8'h00);
      end
      n_checks++;
      if ($isunknown(fifo_level) || int'(fifo_level) != q.size()) begin
        n_fail++;
        $display("FAIL level t=%0t act=%0d exp=%0d",
                 $time, fifo_level, q.size());
      end
      if (char_valid && char_ready) got_q.push_back(char_data);
    end
  end

  task automatic chk(input string name, input longint act,
                     input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s timed out t=%0t", name, $time);
  endtask

  task automatic write_burst(input logic [3:0] id, input int n,
                             input bit no_last);
    int  t;
    bit  got;
    t_awvalid = 1'b1;
    t_awid = id;
    t = 0; got = 0;
    while (!got && t < BOUND) begin
      @(negedge clk); got = miso.awready;
      @(posedge clk); #1; t++;
    end
    if (!got) timeout("aw");
    t_awvalid = 1'b0;
    for (int i = 0; i < n; i++) begin
      t_wvalid = 1'b1;
      t_wdata = {48'hA5A5_5A5A_C3C3, 8'hFF, wr_d[i]};
      t_wstrb = wr_s[i] ? 8'h01 : 8'hFE;
      t_wlast = (i == n - 1) && !no_last;
      t = 0; got = 0;
      while (!got && t < BOUND) begin
        @(negedge clk); got = miso.wready;
        @(posedge clk); #1; t++;
      end
      if (!got) timeout("w");
    end
    t_wvalid = 1'b0;
    t_wlast = 1'b0;
    if (!no_last) begin
      @(negedge clk);
      chk("b_latency", miso.bvalid, 1);
      chk("bid", miso.bid, id);
      chk("bresp", miso.bresp, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("aw_after_b", miso.awready, 1);
      @(posedge clk); #1;
    end
  endtask

  task automatic read_burst(input logic [3:0] id, input logic [7:0] len,
                            input bit toggle);
    int t, beats, last_at, nlast;
    bit got, done;
    t_arvalid = 1'b1;
    t_arid = id;
    t_arlen = len;
    t = 0; got = 0;
    while (!got && t < BOUND) begin
      @(negedge clk); got = miso.arready;
      @(posedge clk); #1; t++;
    end
    if (!got) timeout("ar");
    t_arvalid = 1'b0;
    beats = 0; last_at = 0; nlast = 0; done = 0; t = 0;
    while (!done && t < 2000) begin
      t_rready = toggle ? t[0] : 1'b1;
      @(negedge clk);
      if (miso.rvalid && t_rready) begin
        beats++;
        if (toggle) begin
          chk("rid", miso.rid, id);
          chk("rresp", miso.rresp, 2);
          chk("rdata", miso.rdata, 0);
        end
        if (miso.rlast) begin
          nlast++; last_at = beats; done = 1;
        end
      end
      @(posedge clk); #1; t++;
    end
    t_rready = 1'b0;
    chk("rd_beats", beats, int'(len) + 1);
    chk("rd_last_at", last_at, int'(len) + 1);
    chk("rd_nlast", nlast, 1);
  endtask

  task automatic drain();
    int t;
    char_ready = 1'b1;
    t = 0;
    while (fifo_level != 0 && t < BOUND) begin
      @(negedge clk); t++;
    end
    if (fifo_level != 0) timeout("drain");
    @(posedge clk); #1;
    char_ready = 1'b0;
  endtask

  task automatic chk_got(input string name, input int n);
    chk(name, got_q.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < got_q.size()) chk(name, got_q[i], exp_b[i]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int tt;
    arst = 1'b1;
    char_ready = 1'b0;
    t_awvalid = 0; t_wvalid = 0; t_wlast = 0; t_bready = 1;
    t_arvalid = 0; t_rready = 0;
    t_awid = '0; t_arid = '0; t_arlen = '0;
    t_wdata = '0; t_wstrb = '0;
    repeat (2) @(posedge clk);
    #1 arst = 1'b0;

    @(negedge clk);
    chk("rst_awready", miso.awready, 1);
    chk("rst_arready", miso.arready, 1);
    chk("rst_wready", miso.wready, 0);
    chk("rst_bvalid", miso.bvalid, 0);
    chk("rst_rvalid", miso.rvalid, 0);
    chk("rst_rlast", miso.rlast, 0);
    chk("rst_ids", {miso.bid, miso.rid}, 0);
    chk("rst_resp", {miso.bresp, miso.rresp}, 0);
    chk("rst_char_valid", char_valid, 0);
    chk("rst_char_data", char_data, 0);
    chk("rst_level", fifo_level, 0);
    @(posedge clk); #1;

    // single write
    wr_d[0] = 8'h41; wr_s[0] = 1;
    write_burst(4'd3, 1, 0);
    @(negedge clk);
    chk("t1_char", char_data, 8'h41);
    chk("t1_level", fifo_level, 1);
    @(posedge clk); #1;
    got_q.delete();
    drain();
    exp_b[0] = 8'h41;
    chk_got("t1_got", 1);

    // "HEY\n" held, then streamed
    wr_d[0] = 8'h48; wr_d[1] = 8'h45; wr_d[2] = 8'h59; wr_d[3] = 8'h0A;
    for (int i = 0; i < 4; i++) wr_s[i] = 1;
    write_burst(4'd1, 4, 0);
    @(negedge clk);
    chk("t2_level", fifo_level, 4);
    @(posedge clk); #1;
    char_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_valid", char_valid, 1);
      chk("t2_byte", char_data, wr_d[i]);
    end
    @(negedge clk);
    chk("t2_empty", char_valid, 0);
    chk("t2_level0", fifo_level, 0);
    @(posedge clk); #1;
    char_ready = 1'b0;

    // 20 beats into 16 entries, across pointer wrap
    for (int i = 0; i < 20; i++) begin
      wr_d[i] = 8'h30 + 8'(i); wr_s[i] = 1; exp_b[i] = 8'h30 + 8'(i);
    end
    got_q.delete();
    fork
      write_burst(4'd7, 20, 0);
      begin
        tt = 0;
        while (fifo_level != 5'd16 && tt < BOUND) begin
          @(negedge clk); tt++;
        end
        chk("t3_full_level", fifo_level, 16);
        repeat (3) begin
          @(negedge clk);
          chk("t3_wready", miso.wready, 0);
        end
        @(posedge clk); #1;
        char_ready = 1'b1;
      end
    join
    drain();
    chk_got("t3_got", 20);

    // null-strobe beat in the middle
    wr_d[0] = 8'h61; wr_s[0] = 1;
    wr_d[1] = 8'h7A; wr_s[1] = 0;
    wr_d[2] = 8'h62; wr_s[2] = 1;
    got_q.delete();
    write_burst(4'd2, 3, 0);
    @(negedge clk);
    chk("t4_level", fifo_level, 2);
    @(posedge clk); #1;
    drain();
    exp_b[0] = 8'h61; exp_b[1] = 8'h62;
    chk_got("t4_got", 2);

    // SLVERR read with toggling rready, write in parallel
    wr_d[0] = 8'h5A; wr_s[0] = 1;
    got_q.delete();
    fork
      read_burst(4'd5, 8'd2, 1);
      write_burst(4'd9, 1, 0);
    join
    drain();
    exp_b[0] = 8'h5A;
    chk_got("t5_got", 1);

    // longest read burst
    read_burst(4'd6, 8'd255, 0);

    // reset during W_DATA with two bytes buffered
    wr_d[0] = 8'h11; wr_d[1] = 8'h22; wr_s[0] = 1; wr_s[1] = 1;
    write_burst(4'd2, 2, 1);
    @(negedge clk);
    chk("t6_pre_level", fifo_level, 2);
    @(posedge clk); #1 arst = 1'b1;
    @(posedge clk); #1 arst = 1'b0;
    @(negedge clk);
    chk("t6_awready", miso.awready, 1);
    chk("t6_wready", miso.wready, 0);
    chk("t6_bvalid", miso.bvalid, 0);
    chk("t6_char_valid", char_valid, 0);
    chk("t6_level", fifo_level, 0);
    @(posedge clk); #1;
    wr_d[0] = 8'h4F; wr_d[1] = 8'h4B;
    got_q.delete();
    write_burst(4'd4, 2, 0);
    drain();
    exp_b[0] = 8'h4F; exp_b[1] = 8'h4B;
    chk_got("t6_got", 2);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
